fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. The IF/ID register feeds the decode stage, whose main decoder consumes `ifid_instr[6:0]` as its opcode. The block applies redirects from jumps and taken branches, stalls from the hazard unit, and the decoder's halt request. Bubbles are inserted as canonical NOPs, never as all-zero words, because an opcode of 0 decodes as halt.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_AW`, 9: instruction-memory word-address width.
- `NOP_INSTR`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hazard unit; holds the PC and the IF/ID register.
- `redirect_valid` in 1: taken branch, jal or jalr resolved downstream.
- `redirect_pc` in 32: redirect target.
- `halt_req` in 1: decoder halt output for the instruction in IF/ID.
- `imem_addr` out IMEM_AW: `pc[IMEM_AW+1:2]`.
- `imem_rdata` in 32: instruction word, combinational read of `imem_addr`.
- `ifid_pc` out 32: PC of the registered instruction.
- `ifid_instr` out 32: registered instruction.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: core stopped.
- `perf_fetch_cnt` out 32: fetched-instruction count; see Configuration.
- `perf_stall_cnt` out 32: stall-cycle count; see Configuration.

## Operation
- The state machine has two states, RUN and HALTED. All state is updated on the rising edge of `clk`.
- Reset values:
  - `pc`=RESET_PC
  - `ifid_pc`=0
  - `ifid_instr`=NOP_INSTR
  - `ifid_valid`=0
  - `halted`=0
  - state=RUN
  - both counters=0
- Priority in RUN, highest first: `reset` > redirect > halt > stall > advance.
- Redirect (`redirect_valid`=1):
  - `pc` ← {`redirect_pc[31:2]`,2'b00}; low two bits are forced to zero.
  - IF/ID is flushed: `ifid_instr`=NOP_INSTR, `ifid_valid`=0, `ifid_pc`=0.
  - Redirect overrides `stall` and `halt_req` in the same cycle, because the redirecting instruction is older than the one in IF/ID.
- Halt (`halt_req`=1 and `ifid_valid`=1, no redirect):
  - Next state is HALTED, `halted`=1.
  - IF/ID is flushed as for a redirect. `pc` holds.
  - Halt is taken even when `stall`=1.
  - `halt_req` is ignored whenever `ifid_valid`=0.
- Stall (`stall`=1, no redirect or halt): `pc`, `ifid_*` and state all hold.
- Advance:
  - `ifid_instr` ← `imem_rdata`, `ifid_pc` ← `pc`, `ifid_valid` ← 1.
  - `pc` ← `pc`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- HALTED:
  - `pc` frozen; `ifid_valid`=0; `ifid_instr`=NOP_INSTR; `halted`=1.
  - `stall`, `redirect_valid` and `halt_req` are all ignored.
  - Only `reset` leaves HALTED.
- `imem_addr` is always derived combinationally from the current `pc`. The upper PC bits above IMEM_AW+1 are not range-checked.

## Timing
- Fetch latency is one cycle. The word at `pc` in cycle N appears on `ifid_instr` in cycle N+1.
- After `reset` deasserts, the first valid instruction (`RESET_PC`) appears in IF/ID one cycle later.
- A redirect presented in cycle N:
  - The target is fetched in cycle N+1.
  - The target appears valid in IF/ID in cycle N+2.
  - Exactly one bubble is produced at IF/ID, visible in cycle N+1. Older bubbles in later stages are the EX flush logic's responsibility.
- `halted` rises one cycle after the qualifying `halt_req`.
- `reset` asserted mid-operation, in any state, restores all reset values at the next edge.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetch_cnt` increments on each advance, i.e. each cycle that loads `ifid_valid`=1.
  - `perf_stall_cnt` increments on each RUN cycle in which `stall` is applied (no redirect or halt).
  - Both counters wrap at 2^32, clear on `reset`, and freeze in HALTED.
- `FETCH_PERF_CNT_EN` undefined: the counters are not built, and both ports are tied to 32'h0. The port list is identical in both builds.

## Test plan
- Reset, then run with memory word i = 32'h0000_0013 | (i<<20), no stalls. → `ifid_valid` rises 1 cycle after reset release. `ifid_pc` then reads 0, 4, 8, … with the matching words, one per cycle.
- Assert `stall` for 3 cycles at `pc`=0x10. → `ifid_pc`=0x0C and `imem_addr`=4 hold for 3 cycles, then the sequence resumes at 0x10. With the macro on, `perf_stall_cnt`=3.
- Assert `redirect_valid` with `redirect_pc`=0x43 while `stall`=1. → Next cycle: `ifid_valid`=0, `ifid_instr`=32'h13, `imem_addr`=0x10. The following cycle: `ifid_pc`=0x40.
- Fetch a word 32'h0, then raise `halt_req` while `ifid_valid`=1. → `halted`=1 next cycle, and `pc` is frozen. A later `redirect_valid`=1 is ignored; `reset` restores `pc`=RESET_PC and `halted`=0.
- Assert `halt_req` and `redirect_valid` in the same cycle (target 0x80). → No halt; `ifid_pc`=0x80 two cycles later.
- Set `pc`=32'hFFFF_FFFC via redirect, then advance. → Next `pc`=0; `ifid_pc`=32'hFFFF_FFFC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem addressing and the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 9,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_instr,
    output logic               ifid_valid,
    output logic               halted,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ifid_pc_d;
    logic [31:0] ifid_instr_d;
    logic        ifid_valid_d;

    logic in_run;
    logic do_redirect;
    logic do_halt;
    logic do_stall;
    logic do_advance;

    // The target is word-aligned by dropping these bits.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // One-hot action select: redirect > halt > stall > advance.
    assign in_run      = (state_q == RUN);
    assign do_redirect = in_run && redirect_valid;
    assign do_halt     = in_run && !redirect_valid
                         && halt_req && ifid_valid;
    assign do_stall    = in_run && !redirect_valid
                         && !do_halt && stall;
    assign do_advance  = in_run && !redirect_valid
                         && !do_halt && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (do_halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc;
        ifid_instr_d = ifid_instr;
        ifid_valid_d = ifid_valid;
        unique case (1'b1)
            do_redirect: begin
                pc_d         = {redirect_pc[31:2], 2'b00};
                ifid_pc_d    = 32'h0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            do_halt: begin
                ifid_pc_d    = 32'h0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            do_advance: begin
                pc_d         = pc_q + 32'd4;
                ifid_pc_d    = pc_q;
                ifid_instr_d = imem_rdata;
                ifid_valid_d = 1'b1;
            end
            default: begin
                pc_d         = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ifid_pc    <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ifid_pc    <= ifid_pc_d;
            ifid_instr <= ifid_instr_d;
            ifid_valid <= ifid_valid_d;
        end
    end

    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign halted    = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (do_advance) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (do_stall)   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural reference model checked every cycle,
// plus directed literal checks from the fetch scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    logic [31:0] mem [512];

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 1'b0;

    // Reference model state
    logic [31:0] m_pc, m_ipc, m_instr, m_fc, m_sc;
    logic        m_valid, m_halted;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h13;
            m_valid = 1'b0; m_halted = 1'b0;
            m_fc = 32'h0; m_sc = 32'h0;
            model_on = 1'b1;
        end else if (!m_halted) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_ipc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
            end else if (halt_req && m_valid) begin
                m_halted = 1'b1;
                m_ipc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
            end else if (stall) begin
                m_sc = m_sc + 1;
            end else begin
                m_ipc = m_pc;
                m_instr = mem[(m_pc / 4) % 512];
                m_valid = 1'b1;
                m_pc = m_pc + 4;
                m_fc = m_fc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("imem_addr", {23'h0, imem_addr}, (m_pc / 4) % 512);
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
            chk("halted", {31'h0, halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_cnt, m_fc);
            chk("perf_stall", perf_stall_cnt, m_sc);
`else
            chk("perf_fetch", perf_fetch_cnt, 32'h0);
            chk("perf_stall", perf_stall_cnt, 32'h0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h13 | (i << 20);
        mem[17] = 32'h0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt_req = 1'b0;
        step(); step();
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h13);
        chk("rst_addr", {23'h0, imem_addr}, 32'h0);

        // halt_req with an empty IF/ID is ignored
        reset = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("first_valid", {31'h0, ifid_valid}, 32'h1);
        chk("first_pc", ifid_pc, 32'h0);
        chk("no_halt_empty", {31'h0, halted}, 32'h0);
        step();
        chk("seq_pc1", ifid_pc, 32'h4);
        chk("seq_instr1", ifid_instr, 32'h0010_0013);
        step(); step();
        chk("seq_pc3", ifid_pc, 32'hC);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", ifid_pc, 32'hC);
            chk("stall_addr", {23'h0, imem_addr}, 32'h4);
        end
        stall = 1'b0;
        step();
        chk("resume_pc", ifid_pc, 32'h10);
        chk("resume_instr", ifid_instr, 32'h0040_0013);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt3", perf_stall_cnt, 32'd3);
`endif

        redirect_valid = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
        chk("redir_instr", ifid_instr, 32'h13);
        chk("redir_addr", {23'h0, imem_addr}, 32'h10);
        step();
        chk("redir_pc", ifid_pc, 32'h40);
        step();
        chk("zero_word", ifid_instr, 32'h0);
        chk("zero_pc", ifid_pc, 32'h44);

        halt_req = 1'b1; stall = 1'b1;
        step();
        halt_req = 1'b0; stall = 1'b0;
        chk("halted", {31'h0, halted}, 32'h1);
        chk("halt_flush", {31'h0, ifid_valid}, 32'h0);
        chk("halt_addr", {23'h0, imem_addr}, 32'h12);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(); step();
        redirect_valid = 1'b0;
        chk("halt_hold", {31'h0, imem_addr}, 32'h12);
        chk("halt_stay", {31'h0, halted}, 32'h1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("unhalt", {31'h0, halted}, 32'h0);
        chk("unhalt_addr", {23'h0, imem_addr}, 32'h0);
        step(); step();
        chk("rerun_pc", ifid_pc, 32'h4);

        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        halt_req = 1'b0; redirect_valid = 1'b0;
        chk("hr_nohalt", {31'h0, halted}, 32'h0);
        step();
        chk("hr_pc", ifid_pc, 32'h80);
        chk("hr_valid", {31'h0, ifid_valid}, 32'h1);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr", {23'h0, imem_addr}, 32'h1FF);
        step();
        chk("wrap_ipc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc0", {23'h0, imem_addr}, 32'h0);
        step();
        chk("wrap_next", ifid_pc, 32'h0);

        reset = 1'b1;
        step();
        chk("mid_rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("mid_rst_cnt", perf_fetch_cnt, 32'h0);
        reset = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
